// File: rtl/build_config_pkg.sv
// Shared types and constants for the runtime configuration builder.
package build_config_pkg;

  localparam int NCACHE_P = 2;
  localparam int CFG_W_P  = 32;
  localparam int LOG2_W   = 6;

  localparam int PLEN_RV32       = 34;
  localparam int PLEN_RV64       = 56;
  localparam int GPLEN_RV32      = 34;
  localparam int GPLEN_RV64      = 41;
  localparam int FETCH_WIDTH_MAX = 128;

  typedef struct packed {
    logic [CFG_W_P-1:0] byte_size;
    logic [CFG_W_P-1:0] set_assoc;
    logic [CFG_W_P-1:0] line_width;
  } cache_user_cfg_t;

  typedef struct packed {
    logic [CFG_W_P-1:0]                   xlen;
    logic [CFG_W_P-1:0]                   vlen;
    cache_user_cfg_t [NCACHE_P-1:0]       cache;
  } user_cfg_v2_t;

  typedef struct packed {
    logic [CFG_W_P-1:0] set_assoc;
    logic [CFG_W_P-1:0] set_assoc_width;
    logic [CFG_W_P-1:0] index_width;
    logic [CFG_W_P-1:0] offset_width;
    logic [CFG_W_P-1:0] tag_width;
    logic [CFG_W_P-1:0] line_width;
  } cache_cfg_t;

  typedef struct packed {
    logic [CFG_W_P-1:0]              xlen;
    logic [CFG_W_P-1:0]              vlen;
    logic [CFG_W_P-1:0]              plen;
    logic [CFG_W_P-1:0]              gplen;
    logic [CFG_W_P-1:0]              fetch_width;
    cache_cfg_t [NCACHE_P-1:0]       cache;
  } cfg_v2_t;

  typedef enum logic [2:0] {
    ERR_NONE, ERR_XLEN, ERR_VLEN, ERR_POW2, ERR_GEOM
  } cfg_err_e;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOG2, S_FINAL, S_DONE
  } fsm_state_e;

  function automatic logic is_pow2(input logic [CFG_W_P-1:0] v);
    return (v != '0) && ((v & (v - CFG_W_P'(1))) == '0);
  endfunction

endpackage

// File: rtl/cfg_log2_iter.sv
// Iterative log2 of a power-of-two operand: one right shift per cycle until
// the value reaches 1. An operand 2^k reports done in its (k+1)-th cycle.
module cfg_log2_iter
  import build_config_pkg::*;
#(
  parameter int W = CFG_W_P
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic [W-1:0]      val_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LOG2_W-1:0] log2_o
);

  logic [W-1:0]      sh_q, sh_d, cur;
  logic [LOG2_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic              busy_q, busy_d, active;

  // The start cycle evaluates the fresh operand directly, so 2^0 finishes at once.
  always_comb begin
    cur     = start_i ? val_i : sh_q;
    cnt_cur = start_i ? '0 : cnt_q;
    active  = start_i || busy_q;
    done_o  = active && (cur == W'(1));
    log2_o  = cnt_cur;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (clr_i) begin
      busy_d = 1'b0;
    end else if (active && !done_o) begin
      sh_d   = cur >> 1;
      cnt_d  = cnt_cur + LOG2_W'(1);
      busy_d = 1'b1;
    end else if (done_o) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/cfg_build_unit.sv
// Sequential configuration builder: validates a user config, derives address
// widths and cache geometry with a time-shared log2 engine, returns the result.
module cfg_build_unit
  import build_config_pkg::*;
#(
  parameter int NCACHE = NCACHE_P,
  parameter int CFG_W  = CFG_W_P
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  user_cfg_v2_t req_cfg_i,
  input  logic         abort_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output cfg_v2_t      rsp_cfg_o,
  output cfg_err_e     rsp_err_o
);

  localparam int CIDX_W = (NCACHE > 1) ? $clog2(NCACHE) : 1;

  fsm_state_e      state_q, state_d;
  user_cfg_v2_t    req_q, req_d;
  cfg_v2_t         cfg_q, cfg_d, new_cfg;
  cfg_err_e        err_q, err_d, chk_err;
  logic [NCACHE-1:0][2:0][LOG2_W-1:0] lg_q, lg_d;
  logic [CIDX_W-1:0] cidx_q, cidx_d;
  logic [1:0]        fidx_q, fidx_d;

  logic              eng_start, eng_clr, eng_busy, eng_done;
  logic [CFG_W-1:0]  eng_val;
  logic [LOG2_W-1:0] eng_log2;
  logic              pow_bad, geom_err;
  logic [CFG_W-1:0]  plen;
  logic signed [CFG_W:0] idx_s [NCACHE];
  logic signed [CFG_W:0] tag_s [NCACHE];

  always_comb begin
    pow_bad = 1'b0;
    for (int c = 0; c < NCACHE; c++) begin
      if (!is_pow2(req_q.cache[c].byte_size) || !is_pow2(req_q.cache[c].set_assoc) ||
          (req_q.cache[c].line_width < CFG_W'(8)) || !is_pow2(req_q.cache[c].line_width >> 3))
        pow_bad = 1'b1;
    end
    chk_err = ERR_NONE;
    if (req_q.xlen != CFG_W'(32) && req_q.xlen != CFG_W'(64))
      chk_err = ERR_XLEN;
    else if (req_q.vlen == '0 || req_q.vlen > req_q.xlen)
      chk_err = ERR_VLEN;
    else if (pow_bad)
      chk_err = ERR_POW2;
  end

  // Operand order per cache: byte_size, set_assoc, line bytes.
  always_comb begin
    case (fidx_q)
      2'd0:    eng_val = req_q.cache[cidx_q].byte_size;
      2'd1:    eng_val = req_q.cache[cidx_q].set_assoc;
      default: eng_val = req_q.cache[cidx_q].line_width >> 3;
    endcase
    eng_clr   = (state_q != S_LOG2) || abort_i;
    eng_start = (state_q == S_LOG2) && !eng_busy && !abort_i;
  end

  cfg_log2_iter #(.W(CFG_W)) u_log2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (eng_clr),
    .start_i (eng_start),
    .val_i   (eng_val),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .log2_o  (eng_log2)
  );

  always_comb begin
    plen     = (req_q.xlen == CFG_W'(32)) ? CFG_W'(PLEN_RV32) : CFG_W'(PLEN_RV64);
    new_cfg  = '0;
    new_cfg.xlen  = req_q.xlen;
    new_cfg.vlen  = req_q.vlen;
    new_cfg.plen  = plen;
    new_cfg.gplen = (req_q.xlen == CFG_W'(32)) ? CFG_W'(GPLEN_RV32) : CFG_W'(GPLEN_RV64);
    new_cfg.fetch_width = (req_q.cache[0].line_width > CFG_W'(FETCH_WIDTH_MAX)) ?
                          CFG_W'(FETCH_WIDTH_MAX) : req_q.cache[0].line_width;
    geom_err = 1'b0;
    for (int c = 0; c < NCACHE; c++) begin
      idx_s[c] = (CFG_W+1)'(lg_q[c][0]) - (CFG_W+1)'(lg_q[c][1]) - (CFG_W+1)'(lg_q[c][2]);
      tag_s[c] = (CFG_W+1)'(plen) - idx_s[c] - (CFG_W+1)'(lg_q[c][2]);
      if (idx_s[c][CFG_W] || tag_s[c][CFG_W] || (tag_s[c] == '0))
        geom_err = 1'b1;
      new_cfg.cache[c].set_assoc       = req_q.cache[c].set_assoc;
      new_cfg.cache[c].set_assoc_width = CFG_W'(lg_q[c][1]);
      new_cfg.cache[c].index_width     = idx_s[c][CFG_W-1:0];
      new_cfg.cache[c].offset_width    = CFG_W'(lg_q[c][2]);
      new_cfg.cache[c].tag_width       = tag_s[c][CFG_W-1:0];
      new_cfg.cache[c].line_width      = req_q.cache[c].line_width;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    lg_d    = lg_q;
    cidx_d  = cidx_q;
    fidx_d  = fidx_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          req_d   = req_cfg_i;
          state_d = S_CHECK;
        end
      end
      // A failed check still passes through FINAL, which then commits nothing.
      S_CHECK: begin
        err_d   = chk_err;
        cidx_d  = '0;
        fidx_d  = '0;
        state_d = (chk_err == ERR_NONE) ? S_LOG2 : S_FINAL;
      end
      S_LOG2: begin
        if (eng_done) begin
          lg_d[cidx_q][fidx_q] = eng_log2;
          if (fidx_q == 2'd2) begin
            fidx_d = '0;
            if (cidx_q == CIDX_W'(NCACHE-1)) state_d = S_FINAL;
            else                             cidx_d  = cidx_q + CIDX_W'(1);
          end else begin
            fidx_d = fidx_q + 2'd1;
          end
        end
      end
      S_FINAL: begin
        if (err_q == ERR_NONE) begin
          if (geom_err) err_d = ERR_GEOM;
          else          cfg_d = new_cfg;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i && (state_q == S_CHECK || state_q == S_LOG2 || state_q == S_FINAL)) begin
      state_d = S_IDLE;
      cfg_d   = cfg_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cfg_q   <= '0;
      err_q   <= ERR_NONE;
      lg_q    <= '0;
      cidx_q  <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      lg_q    <= lg_d;
      cidx_q  <= cidx_d;
      fidx_q  <= fidx_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_DONE);
  assign rsp_cfg_o   = cfg_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_cfg_build_unit.sv
// Self-checking bench for cfg_build_unit with a arithmetic reference model.
module tb_cfg_build_unit;
  import build_config_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  user_cfg_v2_t req_cfg = '0;
  logic         abort = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  cfg_v2_t      rsp_cfg;
  cfg_err_e     rsp_err;

  int      checks = 0;
  int      errors = 0;
  cfg_v2_t last_good = '0;

  localparam int LAT_LIMIT = 400;

  always #5 clk = ~clk;

  cfg_build_unit #(.NCACHE(2), .CFG_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cfg_i(req_cfg),
    .abort_i(abort),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_cfg_o(rsp_cfg), .rsp_err_o(rsp_err)
  );

  function automatic bit pow2(input longint v);
    return (v > 0) && ($countones(v) == 1);
  endfunction

  // Reference: error code, resulting rsp_cfg and latency from the plain rules.
  function automatic void model(input user_cfg_v2_t u, input cfg_v2_t prev,
                                output cfg_err_e e, output cfg_v2_t c, output int lat);
    int pl, sum, sw, ow, iw, tw, lb;
    bit pbad, geom;
    cfg_v2_t n;
    c = prev; e = ERR_NONE; lat = 2; pbad = 0; geom = 0; sum = 0; n = '0;
    for (int i = 0; i < 2; i++)
      if (!pow2(u.cache[i].byte_size) || !pow2(u.cache[i].set_assoc) ||
          u.cache[i].line_width < 8 || !pow2(u.cache[i].line_width / 8)) pbad = 1;
    if (u.xlen != 32 && u.xlen != 64) e = ERR_XLEN;
    else if (u.vlen == 0 || u.vlen > u.xlen) e = ERR_VLEN;
    else if (pbad) e = ERR_POW2;
    if (e != ERR_NONE) return;
    pl = (u.xlen == 32) ? 34 : 56;
    n.xlen = u.xlen; n.vlen = u.vlen; n.plen = pl;
    n.gplen = (u.xlen == 32) ? 34 : 41;
    n.fetch_width = (u.cache[0].line_width < 128) ? u.cache[0].line_width : 128;
    for (int i = 0; i < 2; i++) begin
      lb = u.cache[i].line_width / 8;
      ow = $clog2(lb); sw = $clog2(u.cache[i].set_assoc);
      iw = $clog2(u.cache[i].byte_size) - sw - ow;
      tw = pl - iw - ow;
      sum += ($clog2(u.cache[i].byte_size) + 1) + (sw + 1) + (ow + 1);
      if (iw < 0 || tw <= 0) geom = 1;
      n.cache[i].set_assoc = u.cache[i].set_assoc;
      n.cache[i].set_assoc_width = sw;
      n.cache[i].index_width = iw;
      n.cache[i].offset_width = ow;
      n.cache[i].tag_width = tw;
      n.cache[i].line_width = u.cache[i].line_width;
    end
    lat = 2 + sum;
    if (geom) e = ERR_GEOM;
    else c = n;
  endfunction

  function automatic user_cfg_v2_t mk(input int xl, input int vl, input int bs0, input int sa0,
                                      input int lw0, input int bs1, input int sa1, input int lw1);
    user_cfg_v2_t u;
    u.xlen = xl; u.vlen = vl;
    u.cache[0].byte_size = bs0; u.cache[0].set_assoc = sa0; u.cache[0].line_width = lw0;
    u.cache[1].byte_size = bs1; u.cache[1].set_assoc = sa1; u.cache[1].line_width = lw1;
    return u;
  endfunction

  function automatic user_cfg_v2_t rand_cfg(input bit allow_bad);
    user_cfg_v2_t u;
    int xl;
    xl = ($urandom_range(0, 1) == 1) ? 64 : 32;
    u = mk(xl, $urandom_range(1, xl),
           1 << $urandom_range(0, 20), 1 << $urandom_range(0, 4), 8 << $urandom_range(0, 6),
           1 << $urandom_range(0, 20), 1 << $urandom_range(0, 4), 8 << $urandom_range(0, 6));
    if (allow_bad) begin
      case ($urandom_range(0, 9))
        0: u.xlen = ($urandom_range(0, 1) == 1) ? 48 : 128;
        1: u.vlen = 0;
        2: u.vlen = u.xlen + $urandom_range(1, 10);
        3: u.cache[$urandom_range(0, 1)].set_assoc = 3;
        4: u.cache[$urandom_range(0, 1)].line_width = ($urandom_range(0, 1) == 1) ? 4 : 24;
        5: u.cache[1].byte_size = 0;
        default: ;
      endcase
    end
    return u;
  endfunction

  // Accepts u at the next edge and counts edges until rsp_valid is seen.
  task automatic send_req(input user_cfg_v2_t u, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_cfg = u;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack_rsp();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    last_good = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_cfg !== '0 || rsp_err !== ERR_NONE) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b err=%0d cfg_nonzero=%b need 1 0 0 0",
               req_ready, rsp_valid, rsp_err, rsp_cfg != '0);
    end
  endtask

  task automatic test_directed();
    user_cfg_v2_t u;
    cfg_v2_t exp;
    int lat;
    u = mk(64, 39, 4096, 4, 128, 8192, 2, 256);
    exp = '0;
    exp.xlen = 64; exp.vlen = 39; exp.plen = 56; exp.gplen = 41; exp.fetch_width = 128;
    exp.cache[0].set_assoc = 4; exp.cache[0].set_assoc_width = 2; exp.cache[0].index_width = 6;
    exp.cache[0].offset_width = 4; exp.cache[0].tag_width = 46; exp.cache[0].line_width = 128;
    exp.cache[1].set_assoc = 2; exp.cache[1].set_assoc_width = 1; exp.cache[1].index_width = 7;
    exp.cache[1].offset_width = 5; exp.cache[1].tag_width = 44; exp.cache[1].line_width = 256;
    send_req(u, lat);
    checks++;
    if (lat != 45) begin errors++; $display("FAIL directed_latency: got %0d need 45", lat); end
    checks++;
    if (rsp_err !== ERR_NONE) begin errors++; $display("FAIL directed_err: got %0d need 0", rsp_err); end
    checks++;
    if (rsp_cfg !== exp) begin
      errors++;
      $display("FAIL directed_cfg: got plen=%0d idx0=%0d tag0=%0d idx1=%0d tag1=%0d need 56 6 46 7 44",
               rsp_cfg.plen, rsp_cfg.cache[0].index_width, rsp_cfg.cache[0].tag_width,
               rsp_cfg.cache[1].index_width, rsp_cfg.cache[1].tag_width);
    end
    last_good = exp;
    ack_rsp();
  endtask

  task automatic test_errors(input string name, input user_cfg_v2_t u, input cfg_err_e want,
                             input int want_lat);
    int lat;
    send_req(u, lat);
    checks++;
    if (lat != want_lat || rsp_err !== want) begin
      errors++;
      $display("FAIL %s: lat=%0d err=%0d need lat=%0d err=%0d", name, lat, rsp_err, want_lat, want);
    end
    checks++;
    if (rsp_cfg !== last_good) begin errors++; $display("FAIL %s_cfg: rsp_cfg changed on error", name); end
    ack_rsp();
  endtask

  task automatic test_abort();
    user_cfg_v2_t u;
    cfg_v2_t c; cfg_err_e e;
    int lat, want_lat;
    bit seen;
    u = mk(64, 39, 4096, 4, 128, 8192, 2, 256);
    @(negedge clk); req_valid = 1'b1; req_cfg = u;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle: ready=%b valid=%b need 1 0", req_ready, rsp_valid);
    end
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (rsp_valid === 1'b1) seen = 1; end
    checks++;
    if (seen || rsp_cfg !== last_good) begin
      errors++; $display("FAIL abort_quiet: valid_seen=%b cfg_kept=%b need 0 1", seen, rsp_cfg === last_good);
    end
    u = mk(32, 32, 2048, 2, 64, 1024, 1, 32);
    model(u, last_good, e, c, want_lat);
    send_req(u, lat);
    checks++;
    if (lat != want_lat || rsp_err !== e || rsp_cfg !== c) begin
      errors++; $display("FAIL abort_next: lat=%0d err=%0d need lat=%0d err=%0d", lat, rsp_err, want_lat, e);
    end
    if (e == ERR_NONE) last_good = c;
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    user_cfg_v2_t u1, u2;
    cfg_v2_t c, snap_cfg; cfg_err_e e, snap_err;
    int lat, want_lat;
    bit bad;
    u1 = rand_cfg(0); u2 = rand_cfg(0);
    model(u1, last_good, e, c, want_lat);
    send_req(u1, lat);
    checks++;
    if (lat != want_lat || rsp_err !== e || rsp_cfg !== c) begin
      errors++; $display("FAIL bp_first: lat=%0d err=%0d need lat=%0d err=%0d", lat, rsp_err, want_lat, e);
    end
    if (e == ERR_NONE) last_good = c;
    snap_cfg = rsp_cfg; snap_err = rsp_err;
    @(negedge clk); req_valid = 1'b1; req_cfg = u2;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_cfg !== snap_cfg || rsp_err !== snap_err) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_hold: outputs moved or request taken while stalled (bad=%b need 0)", bad); end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_handshake: ready=%b valid=%b need 1 0", req_ready, rsp_valid);
    end
    @(posedge clk); #1; req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: ready=%b need 0", req_ready); end
    model(u2, last_good, e, c, want_lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < LAT_LIMIT) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != want_lat || rsp_err !== e || rsp_cfg !== c) begin
      errors++; $display("FAIL bp_second: lat=%0d err=%0d need lat=%0d err=%0d", lat, rsp_err, want_lat, e);
    end
    if (e == ERR_NONE) last_good = c;
    ack_rsp();
  endtask

  task automatic test_random();
    user_cfg_v2_t u;
    cfg_v2_t c; cfg_err_e e;
    int lat, want_lat;
    for (int i = 0; i < 30; i++) begin
      u = rand_cfg(1);
      model(u, last_good, e, c, want_lat);
      send_req(u, lat);
      checks++;
      if (lat != want_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d need %0d", i, lat, want_lat); end
      checks++;
      if (rsp_err !== e) begin errors++; $display("FAIL rand%0d_err: got %0d need %0d", i, rsp_err, e); end
      checks++;
      if (rsp_cfg !== c) begin
        errors++;
        $display("FAIL rand%0d_cfg: got plen=%0d tag0=%0d idx1=%0d need plen=%0d tag0=%0d idx1=%0d", i,
                 rsp_cfg.plen, rsp_cfg.cache[0].tag_width, rsp_cfg.cache[1].index_width,
                 c.plen, c.cache[0].tag_width, c.cache[1].index_width);
      end
      if (e == ERR_NONE) last_good = c;
      ack_rsp();
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); req_valid = 1'b1; req_cfg = mk(64, 39, 4096, 4, 128, 8192, 2, 256);
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_cfg !== '0 || rsp_err !== ERR_NONE) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ready=%b cfg_zero=%b err=%0d need 0 1 1 0",
               rsp_valid, req_ready, rsp_cfg == '0, rsp_err);
    end
    @(negedge clk); rst_n = 1'b1;
    last_good = '0;
  endtask

  initial begin
    test_reset();
    test_errors("xlen_after_reset", mk(48, 32, 4096, 4, 128, 8192, 2, 256), ERR_XLEN, 2);
    test_directed();
    test_errors("pow2_assoc", mk(64, 39, 4096, 3, 128, 8192, 2, 256), ERR_POW2, 2);
    test_errors("vlen_zero", mk(32, 0, 4096, 4, 128, 8192, 2, 256), ERR_VLEN, 2);
    // 64 B / 4 ways / 32 B lines: index goes negative; LOG2 runs 7+3+6 then 14+2+6.
    test_errors("geom", mk(64, 39, 64, 4, 256, 8192, 2, 256), ERR_GEOM, 2 + 16 + 22);
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
